aes_key_sched_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_key_sched_ctrl_subword.sv | 33 +++
 rtl/aes_key_sched_ctrl.sv | 132 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the AES key-schedule controller and its helpers.
//   AES_NB      : block size in 32-bit words
//   RK_W        : width of one round key in bits
//   ST_*        : FSM state encodings of the key-schedule controller
//   xtime()     : GF(2^8) multiply-by-x, used to step the round constant
package aes_pkg;

  localparam int AES_NB = 4;
  localparam int RK_W   = 128;

  // Kept as plain constants so older blocks that compare raw state bits
  // keep working unchanged.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1. Starting from 8'h01 this
  // walks the round constants 01,02,04,...,80,1b,36.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_subword.sv
// aes_key_sched_ctrl_subword
// Combinational AES SubWord: applies the forward S-box to each byte of a word.
//   word   : 32-bit input word
//   subbed : 32-bit output, S-box applied bytewise
module aes_key_sched_ctrl_subword (
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  // Forward S-box, entry 0 at the most significant end of the packed array.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  assign subbed = {SBOX[word[31:24]], SBOX[word[23:16]],
                   SBOX[word[15:8]],  SBOX[word[7:0]]};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
// Sequential AES key-schedule controller. On start it loads the cipher key and
// then derives one schedule word per clock through a single shared SubWord
// unit, storing all NB*(NR+1) words. Once done, one 128-bit round key is
// served per cycle from the stored schedule.
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high reset
//   start      : begin expansion of key (accepted only while ready)
//   key        : cipher key, word j at key[32j+31:32j], sampled on acceptance
//   ready      : high in IDLE and DONE
//   keys_valid : high in DONE, schedule complete and readable
//   rk_idx     : round-key index 0..NR
//   rk         : registered round key {w[4r+3],w[4r+2],w[4r+1],w[4r]}
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NB = AES_NB,
  parameter int NR = NK + 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [32*NK-1:0]  key,
  output logic              ready,
  output logic              keys_valid,
  input  logic [3:0]        rk_idx,
  output logic [RK_W-1:0]   rk
);

  localparam int         WORDS  = NB * (NR + 1);
  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [5:0] LAST_W = 6'(WORDS - 1);
  localparam logic [2:0] NK_M1  = 3'(NK - 1);
  localparam logic [3:0] NR_W   = 4'(NR);

  logic [1:0]  state;
  logic [5:0]  widx;
  logic [2:0]  kmod;
  logic [31:0] tmp;
  logic [7:0]  rcon;
  logic [31:0] wbuf [WORDS];

  logic        accept;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] tvec;
  logic [31:0] wnew;
  logic [5:0]  rbase;

  assign ready      = (state != ST_EXPAND);
  assign keys_valid = (state == ST_DONE);
  assign accept     = start && ready;
  assign rbase      = {rk_idx, 2'b00};

  // The one S-box unit is fed RotWord(tmp) at the start of each key-length
  // group and plain tmp otherwise; only the 256-bit key actually uses the
  // plain-tmp result (mid-group SubWord).
  aes_key_sched_ctrl_subword u_subword (
    .word   (sub_in),
    .subbed (sub_out)
  );

  // Next schedule word. kmod tracks widx modulo NK so no divider is needed.
  always_comb begin
    sub_in = (kmod == 3'd0) ? {tmp[23:0], tmp[31:24]} : tmp;
    tvec   = tmp;
    if (kmod == 3'd0) begin
      tvec = sub_out ^ {rcon, 24'h0};
    end else if (NK == 8 && kmod == 3'd4) begin
      tvec = sub_out;
    end
    wnew = wbuf[widx - NK_W] ^ tvec;
  end

  // Control FSM: a start from IDLE or DONE primes the counters with the last
  // key word; EXPAND produces one word per cycle until the final word of the
  // schedule has been written. Starts during EXPAND are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      widx  <= '0;
      kmod  <= '0;
      tmp   <= '0;
      rcon  <= '0;
    end else if (accept) begin
      state <= ST_EXPAND;
      widx  <= NK_W;
      kmod  <= '0;
      tmp   <= key[32*NK-1 -: 32];
      rcon  <= 8'h01;
    end else if (state == ST_EXPAND) begin
      tmp  <= wnew;
      widx <= widx + 6'd1;
      kmod <= (kmod == NK_M1) ? 3'd0 : kmod + 3'd1;
      if (kmod == 3'd0) begin
        rcon <= xtime(rcon);
      end
      if (widx == LAST_W) begin
        state <= ST_DONE;
      end
    end
  end

  // Schedule storage. Contents are meaningless until DONE, so no reset; the
  // whole key is written in one go on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < NK; j++) begin
        wbuf[j] <= key[32*j +: 32];
      end
    end else if (state == ST_EXPAND) begin
      wbuf[widx] <= wnew;
    end
  end

  // Round-key read port: refreshed every cycle while the schedule is valid,
  // frozen otherwise so a restart does not disturb the last key served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk <= '0;
    end else if (keys_valid) begin
      if (rk_idx <= NR_W) begin
        rk <= {wbuf[rbase + 6'd3], wbuf[rbase + 6'd2],
               wbuf[rbase + 6'd1], wbuf[rbase]};
      end else begin
        rk <= '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl
// Directed bench for aes_key_sched_ctrl with one instance per key length
// (NK=4/6/8), sharing clock and reset. Expected round keys are the
// FIPS-197 example schedules and the all-zero AES-128 key schedule.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] KEY128 = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [191:0] KEY192 = {32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
                                     32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
  localparam logic [255:0] KEY256 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                     32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};

  localparam logic [127:0] FIPS_RK3  = {32'h6d7a883b, 32'h1e237e44, 32'h4716fe3e, 32'h3d80477d};
  localparam logic [127:0] FIPS_RK10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
  localparam logic [127:0] ZERO_RK1  = {32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363};
  localparam logic [127:0] ZERO_RK3  = {32'h0b0fac99, 32'hf2f45733, 32'h696ccffa, 32'h90973450};
  localparam logic [127:0] ZERO_RK10 = {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start4, ready4, kv4;
  logic [127:0] key4;
  logic [3:0]   idx4;
  logic [127:0] rk4;
  logic         start6, ready6, kv6;
  logic [191:0] key6;
  logic [3:0]   idx6;
  logic [127:0] rk6;
  logic         start8, ready8, kv8;
  logic [255:0] key8;
  logic [3:0]   idx8;
  logic [127:0] rk8;

  aes_key_sched_ctrl #(.NK(4), .NR(10)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .key(key4), .ready(ready4),
    .keys_valid(kv4), .rk_idx(idx4), .rk(rk4));
  aes_key_sched_ctrl #(.NK(6), .NR(12)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .key(key6), .ready(ready6),
    .keys_valid(kv6), .rk_idx(idx6), .rk(rk6));
  aes_key_sched_ctrl #(.NK(8), .NR(14)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .key(key8), .ready(ready8),
    .keys_valid(kv8), .rk_idx(idx8), .rk(rk8));

  typedef struct {
    int           sel;
    logic [3:0]   idx;
    logic [127:0] expRk;
  } vec_t;

  vec_t vecs [$];
  int checks = 0;
  int errors = 0;

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a round-key index to one instance and return the key it serves
  // one edge later.
  task automatic applyStimulus(input int sel, input logic [3:0] idx, output logic [127:0] got);
    case (sel)
      4:       idx4 = idx;
      6:       idx6 = idx;
      default: idx8 = idx;
    endcase
    tick();
    case (sel)
      4:       got = rk4;
      6:       got = rk6;
      default: got = rk8;
    endcase
  endtask

  // Cycles from the accepting edge until keys_valid of the NK=4 instance is
  // seen high; 0 if it never rises within the budget.
  task automatic waitValid4(output int lat);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (kv4) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] got;
    int lat4, lat6, lat8, lat;

    vecs.push_back('{4, 4'd0,  KEY128});
    vecs.push_back('{4, 4'd1,  {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17}});
    vecs.push_back('{4, 4'd2,  {32'h7359f67f, 32'h5935807a, 32'h7a96b943, 32'hf2c295f2}});
    vecs.push_back('{4, 4'd3,  FIPS_RK3});
    vecs.push_back('{4, 4'd9,  {32'h575c006e, 32'h28d12941, 32'h19fadc21, 32'hac7766f3}});
    vecs.push_back('{4, 4'd10, FIPS_RK10});
    vecs.push_back('{4, 4'd11, 128'h0});
    vecs.push_back('{4, 4'd15, 128'h0});
    vecs.push_back('{6, 4'd0,  {32'h809079e5, 32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7}});
    vecs.push_back('{6, 4'd1,  {32'h2402f5a5, 32'hfe0c91f7, 32'h522c6b7b, 32'h62f8ead2}});
    vecs.push_back('{6, 4'd2,  {32'h5c56fec2, 32'h0e7a95b9, 32'h6c827f6b, 32'hec12068e}});
    vecs.push_back('{6, 4'd12, {32'h01002202, 32'h8ecc7204, 32'h448c773c, 32'he98ba06f}});
    vecs.push_back('{6, 4'd13, 128'h0});
    vecs.push_back('{8, 4'd0,  {32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10}});
    vecs.push_back('{8, 4'd1,  {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07}});
    vecs.push_back('{8, 4'd2,  {32'h2067fcde, 32'ha51a8b5f, 32'h8e6925af, 32'h9ba35411}});
    vecs.push_back('{8, 4'd3,  {32'hb75d5b9a, 32'hbe49846e, 32'h93d194cd, 32'ha8b09c1a}});
    vecs.push_back('{8, 4'd4,  {32'hde8ebe96, 32'hfee94248, 32'h5bf3c917, 32'hd59aecb8}});
    vecs.push_back('{8, 4'd14, {32'h706c631e, 32'h046df344, 32'he6188d0b, 32'hfe4890d1}});
    vecs.push_back('{8, 4'd15, 128'h0});

    reset = 1'b1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = KEY128; key6 = KEY192; key8 = KEY256;
    idx4 = 4'd0; idx6 = 4'd0; idx8 = 4'd0;
    tick();
    tick();
    checkOutput("reset_ready4", 128'(ready4), 128'd1);
    checkOutput("reset_kv4",    128'(kv4),    128'd0);
    checkOutput("reset_rk4",    rk4,          128'h0);
    checkOutput("reset_ready8", 128'(ready8), 128'd1);
    checkOutput("reset_rk8",    rk8,          128'h0);
    reset = 1'b0;
    tick();

    // All three key lengths expand side by side from one accepting edge.
    start4 = 1'b1; start6 = 1'b1; start8 = 1'b1;
    tick();
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    checkOutput("accept_ready4", 128'(ready4), 128'd0);
    checkOutput("accept_kv4",    128'(kv4),    128'd0);
    lat4 = 0; lat6 = 0; lat8 = 0;
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (kv4 && lat4 == 0) lat4 = n;
      if (kv6 && lat6 == 0) lat6 = n;
      if (kv8 && lat8 == 0) lat8 = n;
    end
    checkOutput("latency_nk4", 128'(lat4), 128'd40);
    checkOutput("latency_nk6", 128'(lat6), 128'd46);
    checkOutput("latency_nk8", 128'(lat8), 128'd52);
    checkOutput("done_ready4", 128'(ready4), 128'd1);

    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].sel, vecs[v].idx, got);
      checkOutput($sformatf("table_nk%0d_rk%0d", vecs[v].sel, vecs[v].idx), got, vecs[v].expRk);
    end

    // Restart from DONE with the all-zero key while rk_idx=3 stays applied.
    applyStimulus(4, 4'd3, got);
    checkOutput("pre_restart_rk3", got, FIPS_RK3);
    key4 = 128'h0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checkOutput("restart_kv_drop", 128'(kv4), 128'd0);
    checkOutput("restart_rk_hold", rk4, FIPS_RK3);
    waitValid4(lat);
    checkOutput("restart_latency", 128'(lat), 128'd40);
    checkOutput("restart_rk_held", rk4, FIPS_RK3);
    applyStimulus(4, 4'd3, got);
    checkOutput("restart_rk3", got, ZERO_RK3);
    applyStimulus(4, 4'd12, got);
    checkOutput("restart_rk12", got, 128'h0);
    applyStimulus(4, 4'd10, got);
    checkOutput("restart_rk10", got, ZERO_RK10);

    // Starts (carrying a different key) pulsed at cycles 5 and 20 of an
    // expansion must be dropped.
    key4 = KEY128;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      start4 = 1'b0;
      if (kv4) begin
        lat = n;
        break;
      end
      if (n == 4 || n == 19) begin
        checkOutput($sformatf("expand_ready_c%0d", n + 1), 128'(ready4), 128'd0);
        key4 = 128'h0;
        start4 = 1'b1;
      end
    end
    checkOutput("ignored_start_latency", 128'(lat), 128'd40);
    applyStimulus(4, 4'd10, got);
    checkOutput("ignored_start_rk10", got, FIPS_RK10);
    applyStimulus(4, 4'd3, got);
    checkOutput("ignored_start_rk3", got, FIPS_RK3);

    // Reset 17 cycles into an expansion, then expand a different key.
    key4 = KEY128;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (17) tick();
    reset = 1'b1;
    #1;
    checkOutput("midreset_kv4",    128'(kv4),    128'd0);
    checkOutput("midreset_ready4", 128'(ready4), 128'd1);
    checkOutput("midreset_rk4",    rk4,          128'h0);
    tick();
    reset = 1'b0;
    key4 = 128'h0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    waitValid4(lat);
    checkOutput("postreset_latency", 128'(lat), 128'd40);
    applyStimulus(4, 4'd10, got);
    checkOutput("postreset_rk10", got, ZERO_RK10);
    applyStimulus(4, 4'd1, got);
    checkOutput("postreset_rk1", got, ZERO_RK1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
